// File: rtl/sdrc_bank_fsm_pp_if.sv
// Bundle between one bank FSM, its request generator and the transfer controller.
// Timing/config inputs and bank status outputs travel with the command handshakes.
interface sdrc_bank_fsm_pp_if #(
   parameter int ROW_W = 13,
   parameter int COL_W = 13,
   parameter int ID_W  = 4,
   parameter int LEN_W = 7,
   parameter int TW    = 4,
   parameter int IW    = 8
);
   localparam int ADDR_W = (ROW_W > COL_W) ? ROW_W : COL_W;

   // request generator -> bank
   logic             r2b_req;
   logic             r2b_start;
   logic             r2b_last;
   logic             r2b_wrap;
   logic             r2b_write;
   logic             r2b_close;
   logic [ID_W-1:0]  r2b_req_id;
   logic [ROW_W-1:0] r2b_raddr;
   logic [COL_W-1:0] r2b_caddr;
   logic [LEN_W-1:0] r2b_len;
   logic             b2r_ack;

   // bank -> transfer controller
   logic              b2x_req;
   logic [1:0]        b2x_cmd;
   logic [ADDR_W-1:0] b2x_addr;
   logic              b2x_start;
   logic              b2x_last;
   logic              b2x_wrap;
   logic [ID_W-1:0]   b2x_id;
   logic [LEN_W-1:0]  b2x_len;
   logic              x2b_ack;
   logic              x2b_refresh;
   logic              x2b_pre_ok;
   logic              x2b_act_ok;
   logic              x2b_rdok;
   logic              x2b_wrok;
   logic              xfr_ok;

   // timing configuration and bank status
   logic [TW-1:0]    tras_delay;
   logic [TW-1:0]    trp_delay;
   logic [TW-1:0]    trcd_delay;
   logic [TW-1:0]    twr_delay;
   logic [IW-1:0]    idle_close_delay;
   logic [ROW_W-1:0] bank_row;
   logic             bank_valid;
   logic             tras_ok;
   logic [2:0]       bank_state;

   modport master (
      output r2b_req, r2b_start, r2b_last, r2b_wrap, r2b_write, r2b_close,
             r2b_req_id, r2b_raddr, r2b_caddr, r2b_len,
             x2b_ack, x2b_refresh, x2b_pre_ok, x2b_act_ok, x2b_rdok, x2b_wrok, xfr_ok,
             tras_delay, trp_delay, trcd_delay, twr_delay, idle_close_delay,
      input  b2r_ack, b2x_req, b2x_cmd, b2x_addr, b2x_start, b2x_last, b2x_wrap,
             b2x_id, b2x_len, bank_row, bank_valid, tras_ok, bank_state
   );

   modport slave (
      input  r2b_req, r2b_start, r2b_last, r2b_wrap, r2b_write, r2b_close,
             r2b_req_id, r2b_raddr, r2b_caddr, r2b_len,
             x2b_ack, x2b_refresh, x2b_pre_ok, x2b_act_ok, x2b_rdok, x2b_wrok, xfr_ok,
             tras_delay, trp_delay, trcd_delay, twr_delay, idle_close_delay,
      output b2r_ack, b2x_req, b2x_cmd, b2x_addr, b2x_start, b2x_last, b2x_wrap,
             b2x_id, b2x_len, bank_row, bank_valid, tras_ok, bank_state
   );
endinterface

// File: rtl/sdrc_bank_fsm_pp.sv
// Per-bank SDRAM FSM: page hit/miss check, PRE/ACT/RD/WR sequencing with
// tRAS/tRP/tRCD/tWR gating, open/close page policy and idle auto-close.
module sdrc_bank_fsm_pp #(
   parameter int ROW_W       = 13,
   parameter int COL_W       = 13,
   parameter int ID_W        = 4,
   parameter int LEN_W       = 7,
   parameter int TW          = 4,
   parameter int IW          = 8,
   parameter int AP_BIT      = 10,
   parameter int PAGE_POLICY = 0
) (
   input logic                clk,
   input logic                reset,
   sdrc_bank_fsm_pp_if.slave  bus
);
   localparam int ADDR_W = (ROW_W > COL_W) ? ROW_W : COL_W;

   localparam logic [1:0] OP_PRE = 2'b00;
   localparam logic [1:0] OP_ACT = 2'b01;
   localparam logic [1:0] OP_RD  = 2'b10;
   localparam logic [1:0] OP_WR  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRE   = 3'd1,
      S_ACT   = 3'd2,
      S_XFR   = 3'd3,
      S_CLOSE = 3'd4
   } state_t;

   state_t            state;
   logic [ROW_W-1:0]  lat_raddr;
   logic [COL_W-1:0]  lat_caddr;
   logic [ID_W-1:0]   lat_id;
   logic [LEN_W-1:0]  lat_len;
   logic              lat_start;
   logic              lat_last;
   logic              lat_wrap;
   logic              lat_write;
   logic              lat_close;
   logic [ROW_W-1:0]  bank_row;
   logic              bank_valid;
   logic [TW-1:0]     tras_cntr;
   logic [TW-1:0]     timer0;
   logic [TW-1:0]     twr_cntr;
   logic [IW-1:0]     idle_cntr;

   logic              tras_ok;
   logic              twr_ok;
   logic              timer0_ok;
   logic              b2x_req;
   logic              cmd_ack;
   logic              bank_open;
   logic              hit;
   logic              idle_expire;
   logic              close_after;
   logic [1:0]        b2x_cmd;
   logic [ADDR_W-1:0] b2x_addr;

   assign tras_ok     = (tras_cntr == '0);
   assign twr_ok      = (twr_cntr == '0);
   assign timer0_ok   = (timer0 == '0);
   // A refresh in the same cycle already closes the row, so it cannot hit.
   assign bank_open   = bank_valid & ~bus.x2b_refresh;
   assign hit         = bank_open & (bus.r2b_raddr == bank_row);
   assign idle_expire = bank_open & (idle_cntr == '0) & (bus.idle_close_delay != '0);
   assign close_after = (PAGE_POLICY != 0) | lat_close;

   // Handshakes: a transfer happens in the cycle where valid and its accept are
   // both high. b2x_req/cmd/addr stay stable until x2b_ack; a permission input
   // going low only masks b2x_req. b2r_ack mirrors r2b_req while IDLE.
   assign cmd_ack = b2x_req & bus.x2b_ack;

   always_comb begin
      b2x_req = 1'b0;
      case (state)
         S_PRE, S_CLOSE: b2x_req = tras_ok & twr_ok & bus.x2b_pre_ok;
         S_ACT:          b2x_req = timer0_ok & bus.x2b_act_ok;
         S_XFR:          b2x_req = timer0_ok & bus.xfr_ok &
                                   (lat_write ? bus.x2b_wrok : bus.x2b_rdok);
         default:        b2x_req = 1'b0;
      endcase
   end

   always_comb begin
      b2x_cmd  = OP_PRE;
      b2x_addr = ADDR_W'(lat_raddr);
      case (state)
         S_ACT: begin
            b2x_cmd  = OP_ACT;
            b2x_addr = ADDR_W'(lat_raddr);
         end
         S_XFR: begin
            b2x_cmd  = lat_write ? OP_WR : OP_RD;
            b2x_addr = ADDR_W'(lat_caddr);
         end
         S_CLOSE: begin
            b2x_cmd          = OP_PRE;
            b2x_addr         = ADDR_W'(bank_row);
            b2x_addr[AP_BIT] = 1'b0;
         end
         default: begin
            b2x_cmd          = OP_PRE;
            b2x_addr         = ADDR_W'(lat_raddr);
            b2x_addr[AP_BIT] = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         lat_raddr  <= '0;
         lat_caddr  <= '0;
         lat_id     <= '0;
         lat_len    <= '0;
         lat_start  <= 1'b0;
         lat_last   <= 1'b0;
         lat_wrap   <= 1'b0;
         lat_write  <= 1'b0;
         lat_close  <= 1'b0;
         bank_row   <= '0;
         bank_valid <= 1'b0;
         tras_cntr  <= '0;
         timer0     <= '0;
         twr_cntr   <= '0;
         idle_cntr  <= '0;
      end else begin
         if (!tras_ok)   tras_cntr <= tras_cntr - TW'(1);
         if (!timer0_ok) timer0    <= timer0 - TW'(1);
         if (!twr_ok)    twr_cntr  <= twr_cntr - TW'(1);

         case (state)
            S_IDLE: begin
               if (bus.r2b_req) begin
                  lat_raddr <= bus.r2b_raddr;
                  lat_caddr <= bus.r2b_caddr;
                  lat_id    <= bus.r2b_req_id;
                  lat_len   <= bus.r2b_len;
                  lat_start <= bus.r2b_start;
                  lat_last  <= bus.r2b_last;
                  lat_wrap  <= bus.r2b_wrap;
                  lat_write <= bus.r2b_write;
                  lat_close <= bus.r2b_close;
                  idle_cntr <= bus.idle_close_delay;
                  if (hit)            state <= S_XFR;
                  else if (bank_open) state <= S_PRE;
                  else                state <= S_ACT;
               end else if (idle_expire) begin
                  state <= S_CLOSE;
               end else if (bank_valid && idle_cntr != '0) begin
                  idle_cntr <= idle_cntr - IW'(1);
               end
            end
            S_PRE: begin
               if (bus.x2b_refresh) begin
                  state <= S_ACT;
               end else if (cmd_ack) begin
                  state      <= S_ACT;
                  bank_valid <= 1'b0;
                  timer0     <= bus.trp_delay;
               end
            end
            S_ACT: begin
               if (!bus.x2b_refresh && cmd_ack) begin
                  state      <= S_XFR;
                  bank_row   <= lat_raddr;
                  bank_valid <= 1'b1;
                  timer0     <= bus.trcd_delay;
                  tras_cntr  <= bus.tras_delay;
               end
            end
            S_XFR: begin
               if (bus.x2b_refresh) begin
                  state <= S_ACT;
               end else if (cmd_ack) begin
                  if (lat_write) twr_cntr <= bus.twr_delay;
                  if (close_after) begin
                     state <= S_CLOSE;
                  end else begin
                     state     <= S_IDLE;
                     idle_cntr <= bus.idle_close_delay;
                  end
               end
            end
            S_CLOSE: begin
               if (bus.x2b_refresh) begin
                  state     <= S_IDLE;
                  idle_cntr <= bus.idle_close_delay;
               end else if (cmd_ack) begin
                  state      <= S_IDLE;
                  bank_valid <= 1'b0;
                  timer0     <= bus.trp_delay;
                  idle_cntr  <= bus.idle_close_delay;
               end
            end
            default: state <= S_IDLE;
         endcase

         if (bus.x2b_refresh) bank_valid <= 1'b0;
      end
   end

   assign bus.b2r_ack    = (state == S_IDLE) & bus.r2b_req & ~reset;
   assign bus.b2x_req    = b2x_req;
   assign bus.b2x_cmd    = b2x_cmd;
   assign bus.b2x_addr   = b2x_addr;
   assign bus.b2x_start  = lat_start;
   assign bus.b2x_last   = lat_last;
   assign bus.b2x_wrap   = lat_wrap;
   assign bus.b2x_id     = lat_id;
   assign bus.b2x_len    = lat_len;
   assign bus.bank_row   = bank_row;
   assign bus.bank_valid = bank_valid;
   assign bus.tras_ok    = tras_ok;
   assign bus.bank_state = state;
endmodule

// File: tb/tb_sdrc_bank_fsm_pp.sv
// Directed bench for sdrc_bank_fsm_pp: expected {cmd,addr} words are queued when
// a request is issued and popped as the bank presents each command.
module tb_sdrc_bank_fsm_pp;
   localparam int ROW_W = 13;
   localparam int COL_W = 13;
   localparam int ID_W  = 4;
   localparam int LEN_W = 7;
   localparam int TW    = 4;
   localparam int IW    = 8;
   localparam int W     = 15;

   localparam logic [1:0] OP_PRE = 2'b00;
   localparam logic [1:0] OP_ACT = 2'b01;
   localparam logic [1:0] OP_RD  = 2'b10;
   localparam logic [1:0] OP_WR  = 2'b11;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ACT  = 3'd2;
   localparam logic [2:0] ST_XFR  = 3'd3;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_err = 0;
   logic [W-1:0] exp_q[$];

   sdrc_bank_fsm_pp_if #(.ROW_W(ROW_W), .COL_W(COL_W), .ID_W(ID_W), .LEN_W(LEN_W),
                         .TW(TW), .IW(IW)) bus ();

   sdrc_bank_fsm_pp #(.ROW_W(ROW_W), .COL_W(COL_W), .ID_W(ID_W), .LEN_W(LEN_W),
                      .TW(TW), .IW(IW), .AP_BIT(10), .PAGE_POLICY(0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // clock / cycle index
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [W-1:0] cw(input logic [1:0] c, input logic [12:0] a);
      return {c, a};
   endfunction

   task automatic next_slot();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // driver: present one request in an IDLE slot, check the ack, then drop it
   task automatic issue_req(input string tag, input logic [12:0] row, input logic [12:0] col,
                            input logic wr, input logic cls, input logic [3:0] id,
                            input logic [6:0] len, output int acc);
      bus.r2b_req    = 1'b1;
      bus.r2b_raddr  = row;
      bus.r2b_caddr  = col;
      bus.r2b_write  = wr;
      bus.r2b_close  = cls;
      bus.r2b_req_id = id;
      bus.r2b_len    = len;
      bus.r2b_start  = 1'b1;
      bus.r2b_last   = 1'b1;
      bus.r2b_wrap   = 1'b0;
      #1;
      chk({tag, "_ack"}, bus.b2r_ack, 1);
      acc = cyc;
      next_slot();
      bus.r2b_req   = 1'b0;
      bus.r2b_close = 1'b0;
   endtask

   // scoreboard side: wait (bounded) for b2x_req, compare with queue head, ack it
   task automatic expect_cmd(input string tag, output int seen);
      logic got;
      logic [W-1:0] exp_w;
      got  = 1'b0;
      seen = -1;
      for (int i = 0; i < 40 && !got; i++) begin
         #1;
         if (bus.b2x_req === 1'b1) begin
            got  = 1'b1;
            seen = cyc;
            if (exp_q.size() > 0) exp_w = exp_q.pop_front();
            else                  exp_w = 'x;
            chk({tag, "_cmd"}, {bus.b2x_cmd, bus.b2x_addr}, exp_w);
            bus.x2b_ack = 1'b1;
         end
         next_slot();
         bus.x2b_ack = 1'b0;
      end
      chk({tag, "_seen"}, got, 1);
      if (!got && exp_q.size() > 0) exp_w = exp_q.pop_front();
   endtask

   initial begin
      int   t_acc, t_act, t_rd, t_wr, t_pre, t_cls, t_x;
      logic quiet;

      bus.r2b_req = 1'b0;     bus.r2b_start = 1'b0;  bus.r2b_last = 1'b0;
      bus.r2b_wrap = 1'b0;    bus.r2b_write = 1'b0;  bus.r2b_close = 1'b0;
      bus.r2b_req_id = '0;    bus.r2b_raddr = '0;    bus.r2b_caddr = '0;
      bus.r2b_len = '0;       bus.x2b_ack = 1'b0;    bus.x2b_refresh = 1'b0;
      bus.x2b_pre_ok = 1'b1;  bus.x2b_act_ok = 1'b1; bus.x2b_rdok = 1'b1;
      bus.x2b_wrok = 1'b1;    bus.xfr_ok = 1'b1;
      bus.tras_delay = 4'd3;  bus.trp_delay = 4'd1;  bus.trcd_delay = 4'd2;
      bus.twr_delay = 4'd0;   bus.idle_close_delay = 8'd0;

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("rst_state", bus.bank_state, ST_IDLE);
      chk("rst_b2r_ack", bus.b2r_ack, 0);
      chk("rst_b2x_req", bus.b2x_req, 0);
      chk("rst_bank_valid", bus.bank_valid, 0);
      chk("rst_bank_row", bus.bank_row, 0);
      chk("rst_tras_ok", bus.tras_ok, 1);
      chk("rst_cmd", bus.b2x_cmd, OP_PRE);
      chk("rst_addr", bus.b2x_addr, 0);
      chk("rst_id_len", {bus.b2x_id, bus.b2x_len}, 0);
      next_slot();

      // cold miss: ACT then RD after trcd
      exp_q.push_back(cw(OP_ACT, 13'h005));
      exp_q.push_back(cw(OP_RD, 13'h010));
      issue_req("cold", 13'h005, 13'h010, 1'b0, 1'b0, 4'h3, 7'd8, t_acc);
      expect_cmd("cold_act", t_act);
      chk("cold_act_lat", t_act, t_acc + 1);
      expect_cmd("cold_rd", t_rd);
      chk("cold_rd_lat", t_rd, t_act + 3);
      #1;
      chk("cold_bank_row", bus.bank_row, 13'h005);
      chk("cold_bank_valid", bus.bank_valid, 1);
      chk("cold_state", bus.bank_state, ST_IDLE);
      chk("cold_id", bus.b2x_id, 4'h3);
      chk("cold_len", bus.b2x_len, 7'd8);
      chk("cold_last", bus.b2x_last, 1);
      next_slot();

      // hit (WR) then miss gated by tWR
      bus.twr_delay = 4'd3;
      exp_q.push_back(cw(OP_WR, 13'h020));
      issue_req("hit", 13'h005, 13'h020, 1'b1, 1'b0, 4'h4, 7'd2, t_acc);
      expect_cmd("hit_wr", t_wr);
      chk("hit_wr_lat", t_wr, t_acc + 1);
      bus.twr_delay = 4'd0;
      exp_q.push_back(cw(OP_PRE, 13'h006));
      exp_q.push_back(cw(OP_ACT, 13'h006));
      exp_q.push_back(cw(OP_RD, 13'h030));
      issue_req("miss", 13'h006, 13'h030, 1'b0, 1'b0, 4'h5, 7'd4, t_acc);
      expect_cmd("miss_pre", t_pre);
      chk("miss_pre_twr", t_pre, t_wr + 4);
      expect_cmd("miss_act", t_act);
      chk("miss_act_trp", t_act, t_pre + 2);
      expect_cmd("miss_rd", t_rd);
      #1;
      chk("miss_bank_row", bus.bank_row, 13'h006);
      next_slot();

      // close hint on a row with AP bit set: PRE/CLOSE addresses drop bit 10
      exp_q.push_back(cw(OP_PRE, 13'h006));
      exp_q.push_back(cw(OP_ACT, 13'h406));
      exp_q.push_back(cw(OP_RD, 13'h040));
      exp_q.push_back(cw(OP_PRE, 13'h006));
      issue_req("cls", 13'h406, 13'h040, 1'b0, 1'b1, 4'h6, 7'd1, t_acc);
      expect_cmd("cls_pre", t_pre);
      expect_cmd("cls_act", t_act);
      expect_cmd("cls_rd", t_rd);
      expect_cmd("cls_close", t_cls);
      chk("cls_close_lat", t_cls, t_rd + 1);
      #1;
      chk("cls_bank_valid", bus.bank_valid, 0);
      chk("cls_state", bus.bank_state, ST_IDLE);
      next_slot();

      // same row again must re-activate; then idle auto-close after 5 cycles
      bus.idle_close_delay = 8'd5;
      exp_q.push_back(cw(OP_ACT, 13'h406));
      exp_q.push_back(cw(OP_RD, 13'h044));
      issue_req("reopen", 13'h406, 13'h044, 1'b0, 1'b0, 4'h7, 7'd1, t_acc);
      expect_cmd("reopen_act", t_act);
      chk("reopen_act_lat", t_act, t_acc + 1);
      expect_cmd("reopen_rd", t_rd);
      exp_q.push_back(cw(OP_PRE, 13'h006));
      expect_cmd("idle_close", t_cls);
      chk("idle_close_lat", t_cls, t_rd + 7);
      #1;
      chk("idle_close_valid", bus.bank_valid, 0);
      next_slot();

      // idle auto-close disabled: row stays open
      bus.idle_close_delay = 8'd0;
      exp_q.push_back(cw(OP_ACT, 13'h007));
      exp_q.push_back(cw(OP_RD, 13'h011));
      issue_req("open", 13'h007, 13'h011, 1'b0, 1'b0, 4'h8, 7'd1, t_acc);
      expect_cmd("open_act", t_x);
      expect_cmd("open_rd", t_x);
      quiet = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (bus.b2x_req !== 1'b0) quiet = 1'b0;
         next_slot();
      end
      chk("idle_off_quiet", quiet, 1);
      #1;
      chk("idle_off_valid", bus.bank_valid, 1);
      next_slot();

      // refresh in XFR while held off by xfr_ok, with x2b_ack also high
      bus.xfr_ok = 1'b0;
      issue_req("ref", 13'h007, 13'h050, 1'b0, 1'b0, 4'h9, 7'd1, t_acc);
      #1;
      chk("ref_state_xfr", bus.bank_state, ST_XFR);
      chk("ref_perm_drop", bus.b2x_req, 0);
      bus.x2b_refresh = 1'b1;
      bus.x2b_ack     = 1'b1;
      next_slot();
      bus.x2b_refresh = 1'b0;
      bus.x2b_ack     = 1'b0;
      #1;
      chk("ref_state_act", bus.bank_state, ST_ACT);
      chk("ref_bank_valid", bus.bank_valid, 0);
      bus.xfr_ok = 1'b1;
      exp_q.push_back(cw(OP_ACT, 13'h007));
      exp_q.push_back(cw(OP_RD, 13'h050));
      next_slot();
      expect_cmd("ref_act", t_x);
      expect_cmd("ref_rd", t_x);

      // reset while waiting for ACT permission
      bus.x2b_act_ok = 1'b0;
      exp_q.push_back(cw(OP_PRE, 13'h008));
      issue_req("rst", 13'h008, 13'h060, 1'b0, 1'b0, 4'ha, 7'd1, t_acc);
      expect_cmd("rst_pre", t_x);
      next_slot();
      next_slot();
      #1;
      chk("rstw_state", bus.bank_state, ST_ACT);
      chk("rstw_req", bus.b2x_req, 0);
      reset = 1'b1;
      next_slot();
      reset = 1'b0;
      bus.x2b_act_ok = 1'b1;
      #1;
      chk("rstw_b2x_req", bus.b2x_req, 0);
      chk("rstw_bank_valid", bus.bank_valid, 0);
      chk("rstw_idle", bus.bank_state, ST_IDLE);

      chk("exp_q_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
